// File: rtl/button_pkg.sv
// Shared definitions for the bomb-defuse button sequencer: button codes, game states, strike width.
package button_pkg;

   localparam logic [3:0] UP1 = 4'b0000;
   localparam logic [3:0] UP2 = 4'b0001;
   localparam logic [3:0] DN1 = 4'b0010;
   localparam logic [3:0] DN2 = 4'b0011;
   localparam logic [3:0] LT1 = 4'b0100;
   localparam logic [3:0] LT2 = 4'b0101;
   localparam logic [3:0] RT1 = 4'b0110;
   localparam logic [3:0] RT2 = 4'b0111;
   localparam logic [3:0] A1  = 4'b1000;
   localparam logic [3:0] A2  = 4'b1001;
   localparam logic [3:0] X1  = 4'b1010;
   localparam logic [3:0] X2  = 4'b1011;
   localparam logic [3:0] B1  = 4'b1100;
   localparam logic [3:0] B2  = 4'b1101;

   localparam int STRIKES_W = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRAW     = 3'd1,
      SHOW     = 3'd2,
      WAIT_IN  = 3'd3,
      DEFUSED  = 3'd4,
      EXPLODED = 3'd5
   } state_e;

endpackage

// File: rtl/seq_buf.sv
// Sequence storage: SEQ_MAX x 4-bit register file, one write port, one combinational read port.
module seq_buf #(
   parameter int SEQ_MAX = 8,
   parameter int AW      = $clog2(SEQ_MAX)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [3:0]    rdata
);

   logic [3:0] mem_q [SEQ_MAX];

   // Contents are deliberately not reset; only entries below the current length are ever read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/button_round_ctrl.sv
// Bomb-defuse game sequencer: grows a code sequence, replays it, checks presses, counts strikes.
// Optional BUTTON_NO_REPEAT_EN: resample a code equal to the previous one (4th sample always kept).
//   state    | meaning
//   IDLE     | no game since reset
//   DRAW     | append rand_code to the sequence
//   SHOW     | replay sequence, SHOW_CYCLES on + 1 gap cycle per code
//   WAIT_IN  | check player presses, timeout counter running
//   DEFUSED  | all SEQ_MAX rounds completed
//   EXPLODED | STRIKES_MAX strikes reached
module button_round_ctrl
   import button_pkg::*;
#(
   parameter int SEQ_MAX        = 8,
   parameter int SHOW_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int STRIKES_MAX    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           rand_code,
   input  logic                 btn_valid,
   input  logic [3:0]           btn_code,
   output logic                 prompt_valid,
   output logic [3:0]           prompt_code,
   output logic [3:0]           round_len,
   output logic [STRIKES_W-1:0] strikes,
   output logic                 busy,
   output logic                 defused,
   output logic                 exploded
);

   localparam int TMAX = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int AW   = $clog2(SEQ_MAX);

   state_e               state_q, state_d;
   logic [3:0]           len_q, len_d;
   logic [3:0]           idx_q, idx_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [STRIKES_W-1:0] strikes_q, strikes_d, strikes_inc;
   logic                 buf_we;
   logic                 do_strike;
   logic                 draw_ok;
   logic [AW-1:0]        rd_addr;
   logic [3:0]           rd_data;

`ifdef BUTTON_NO_REPEAT_EN
   logic [1:0] tries_q, tries_d;

   // In DRAW the read port looks at the previous code to detect a repeat.
   assign rd_addr = (state_q == DRAW) ? AW'(len_q - 4'd1) : AW'(idx_q);
   assign draw_ok = (len_q == 4'd0) || (rand_code != rd_data) || (tries_q == 2'd3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tries_q <= 2'd0;
      end else begin
         tries_q <= tries_d;
      end
   end
`else
   assign rd_addr = AW'(idx_q);
   assign draw_ok = 1'b1;
`endif

   seq_buf #(
      .SEQ_MAX (SEQ_MAX),
      .AW      (AW)
   ) u_seq_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (AW'(len_q)),
      .wdata (rand_code),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         len_q     <= 4'd0;
         idx_q     <= 4'd0;
         timer_q   <= '0;
         strikes_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         timer_q   <= timer_d;
         strikes_q <= strikes_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      timer_d     = timer_q;
      strikes_d   = strikes_q;
      strikes_inc = strikes_q + STRIKES_W'(1);
      buf_we      = 1'b0;
      do_strike   = 1'b0;
`ifdef BUTTON_NO_REPEAT_EN
      tries_d     = tries_q;
`endif
      case (state_q)
         IDLE, DEFUSED, EXPLODED: begin
            if (start) begin
               state_d   = DRAW;
               len_d     = 4'd0;
               strikes_d = '0;
            end
         end
         DRAW: begin
            if (draw_ok) begin
               buf_we  = 1'b1;
               len_d   = len_q + 4'd1;
               idx_d   = 4'd0;
               timer_d = '0;
               state_d = SHOW;
            end
`ifdef BUTTON_NO_REPEAT_EN
            tries_d = draw_ok ? 2'd0 : tries_q + 2'd1;
`endif
         end
         SHOW: begin
            // timer == SHOW_CYCLES is the blank gap separating consecutive prompts
            if (timer_q == TW'(SHOW_CYCLES)) begin
               timer_d = '0;
               if (idx_q == len_q - 4'd1) begin
                  idx_d   = 4'd0;
                  state_d = WAIT_IN;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WAIT_IN: begin
            if (btn_valid) begin
               if (btn_code == rd_data) begin
                  if (idx_q == len_q - 4'd1) begin
                     state_d = (len_q == 4'(SEQ_MAX)) ? DEFUSED : DRAW;
                  end else begin
                     idx_d   = idx_q + 4'd1;
                     timer_d = '0;
                  end
               end else begin
                  do_strike = 1'b1;
               end
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               do_strike = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_strike) begin
         strikes_d = strikes_inc;
         idx_d     = 4'd0;
         timer_d   = '0;
         state_d   = (strikes_inc == STRIKES_W'(STRIKES_MAX)) ? EXPLODED : SHOW;
      end
   end

   assign prompt_valid = (state_q == SHOW) && (timer_q != TW'(SHOW_CYCLES));
   assign prompt_code  = prompt_valid ? rd_data : 4'd0;
   assign round_len    = len_q;
   assign strikes      = strikes_q;
   assign busy         = (state_q == DRAW) || (state_q == SHOW) || (state_q == WAIT_IN);
   assign defused      = (state_q == DEFUSED);
   assign exploded     = (state_q == EXPLODED);

endmodule

// File: doc/button_round_ctrl.md
Name: button_round_ctrl

Overview:
- Game sequencer for the bomb-defuse puzzle.
- Draws button codes from the LFSR prompt generator and builds a growing sequence, one code per round.
- Replays the sequence on the prompt display, then checks the player's presses against it.
- Counts strikes, and declares the bomb defused or exploded.
- Sits between the LFSR (rand_code) and the button decoder / display logic.

Parameters:
- SEQ_MAX, 8, rounds needed to defuse; sequence buffer depth (2..15).
- SHOW_CYCLES, 16, clk cycles each prompt is displayed.
- TIMEOUT_CYCLES, 64, max clk cycles allowed between presses in WAIT_IN.
- STRIKES_MAX, 3, strikes that cause explosion (1..3).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (block in reset while 0).
- start  input  1  one-cycle pulse; begins a game from IDLE, DEFUSED or EXPLODED.
- rand_code  input  4  current LFSR button code (UP1..B2 encoding).
- btn_valid  input  1  one-cycle pulse, a debounced button press.
- btn_code  input  4  code of the pressed button, valid with btn_valid.
- prompt_valid  output  1  a prompt is being displayed.
- prompt_code  output  4  code being displayed; 0 when prompt_valid=0.
- round_len  output  4  current sequence length.
- strikes  output  2  strikes accumulated this game.
- busy  output  1  high in every state except IDLE, DEFUSED, EXPLODED.
- defused  output  1  high while in DEFUSED.
- exploded  output  1  high while in EXPLODED.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; idx, timer, len, strikes = 0. Buffer contents are don't-care.
- IDLE: start -> DRAW. Clears len and strikes.
- DRAW, 1 cycle:
  - seq[len] <= rand_code; len <= len+1.
  - Next state SHOW with idx=0, timer=0.
- SHOW:
  - prompt_valid=1, prompt_code=seq[idx] for SHOW_CYCLES cycles.
  - Then 1 gap cycle with prompt_valid=0, so repeated codes read as separate prompts.
  - idx advances after each gap cycle.
  - After the gap of the last element (idx=len-1) -> WAIT_IN with idx=0, timer=0.
- WAIT_IN: timer increments each cycle without btn_valid.
  - btn_valid with btn_code==seq[idx], and idx<len-1: idx++, timer=0.
  - btn_valid with btn_code==seq[idx], and idx==len-1: len==SEQ_MAX -> DEFUSED, else -> DRAW.
  - btn_valid with a mismatched code, or timer==TIMEOUT_CYCLES-1 with no press: strike.
    - strikes++.
    - If the new strikes value equals STRIKES_MAX -> EXPLODED.
    - Otherwise -> SHOW with idx=0, replaying the same sequence; len is unchanged.
  - btn_valid in the same cycle as the timeout: the press is evaluated; the timeout is discarded.
- DEFUSED / EXPLODED: outputs held until start. start -> DRAW, with len and strikes cleared in that same transition.
- btn_valid outside WAIT_IN: ignored, no strike.
- start while busy: ignored.
- round_len reflects len, updated the cycle after DRAW.
- strikes updates the cycle after the strike event.
- Reset mid-operation: immediate return to IDLE; no output glitches beyond the async clear.

Optional Feature:
- Macro: BUTTON_NO_REPEAT_EN.
- Defined: in DRAW, if len>0 and rand_code==seq[len-1], stay in DRAW and resample the next cycle; the LFSR advances every cycle.
  - Bounded at 4 attempts; the 4th sample is accepted unconditionally.
- Undefined: DRAW always takes 1 cycle and accepts any code.

Decomposition:
- button_pkg holds:
  - button code localparams (UP1=4'b0000 .. B2=4'b1101);
  - the state enum {IDLE, DRAW, SHOW, WAIT_IN, DEFUSED, EXPLODED};
  - the STRIKES width constant.
- Sub-module seq_buf: SEQ_MAX x 4-bit register file.
  - 1 write port (we, waddr, wdata).
  - 1 combinational read port (raddr -> rdata).
  - No reset on contents.

Test Plan (SEQ_MAX=3, SHOW_CYCLES=4, TIMEOUT_CYCLES=16, STRIKES_MAX=3):
1. Reset low mid-SHOW -> all outputs 0 asynchronously. After release, start -> busy=1 next cycle; round_len=1; prompt_valid high 4 cycles, then low 1 cycle.
2. Force rand_code 4'b0010, 4'b1100, 4'b0101 over the three DRAWs, and echo each sequence correctly. -> defused=1 after the 3rd correct press of round 3; round_len=3; strikes=0.
3. Round 1 (seq={0010}): press 4'b0011 -> strikes=1. SHOW replays 0010 and round_len stays 1. Correct press then -> DRAW, round_len=2.
4. In WAIT_IN, no press for 16 cycles -> strikes increments on cycle 16. Press arrives in that exact cycle and is correct -> no strike, idx advances.
5. Three wrong presses across replays -> exploded=1 and busy=0. Further btn_valid -> no change. start -> strikes=0, round_len=1.
6. BUTTON_NO_REPEAT_EN defined, rand_code held at 4'b1000 for 6 cycles -> DRAW lasts exactly 4 cycles and seq[1]=1000. Without the macro -> DRAW lasts 1 cycle.
